// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a DEPTH-entry FIFO of {pc, inst, exp_flag,
// inst_addr_misal} between fetch and decode. Fetch can run ahead while
// decode stalls. A redirect (flush, taken branch/jump, mret) empties the
// queue in one cycle.
//
// Handshake, both sides: a transfer happens on a rising clock edge when the
// producer's valid and the consumer's allowin are both high in that cycle.
// allowin may depend on valid from the other side of the queue, but never on
// the same side's valid. Valid and payload hold steady until the transfer.
`ifndef CPU_RST_ADDR
`define CPU_RST_ADDR 32'h8000_0000
`endif

module if_id_queue #(
  parameter int               XLEN   = 32,
  parameter int               DEPTH  = 4,
  parameter logic [XLEN-1:0]  RST_PC = `CPU_RST_ADDR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pipe_stall,
  input  logic                       pipe_flush,
  input  logic                       ex_bj_flag,
  input  logic                       ex_is_mret_inst,
  input  logic                       if_valid,
  output logic                       if_allowin,
  input  logic [XLEN-1:0]            if_pc,
  input  logic [XLEN-1:0]            if_inst,
  input  logic                       if_exp_flag,
  input  logic                       if_inst_addr_misal,
  output logic                       id_valid,
  input  logic                       id_allowin,
  output logic [XLEN-1:0]            id_pc,
  output logic [XLEN-1:0]            id_inst,
  output logic                       id_exp_flag,
  output logic                       id_inst_addr_misal,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       q_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] pc_d    [DEPTH];
  logic [XLEN-1:0] inst_q  [DEPTH];
  logic [XLEN-1:0] inst_d  [DEPTH];
  logic            exp_q   [DEPTH];
  logic            exp_d   [DEPTH];
  logic            misal_q [DEPTH];
  logic            misal_d [DEPTH];

  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            flush;
  logic            push;
  logic            pop;

  // Handshake qualification; flush overrides both sides in its cycle.
  always_comb begin
    flush      = pipe_flush | ex_bj_flag | ex_is_mret_inst;
    q_full     = (count_q == CW'(DEPTH));
    id_valid   = (count_q != '0) & ~flush;
    pop        = id_valid & id_allowin;
    if_allowin = ~flush & ~pipe_stall & (~q_full | pop);
    push       = if_valid & if_allowin;
  end

  // Head entry drives decode directly; no bypass from the push side.
  always_comb begin
    id_pc              = pc_q[rptr_q];
    id_inst            = inst_q[rptr_q];
    id_exp_flag        = exp_q[rptr_q];
    id_inst_addr_misal = misal_q[rptr_q];
    q_count            = count_q;
  end

  // Next-state for pointers, occupancy and the written slot. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    exp_d   = exp_q;
    misal_d = misal_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      // Slot contents are left as they are; only bookkeeping is cleared.
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d[wptr_q]    = if_pc;
        inst_d[wptr_q]  = if_inst;
        exp_d[wptr_q]   = if_exp_flag;
        misal_d[wptr_q] = if_inst_addr_misal;
        wptr_d          = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State registers with asynchronous reset of every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= RST_PC;
        inst_q[i]  <= '0;
        exp_q[i]   <= 1'b0;
        misal_q[i] <= 1'b0;
      end
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      exp_q   <= exp_d;
      misal_q <= misal_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4): reset values, latency, fill to
// full, push-while-full, redirect flush, fetch stall drain, flag transport
// and asynchronous reset.
module tb_if_id_queue;

  localparam int              XLEN   = 32;
  localparam int              DEPTH  = 4;
  localparam logic [XLEN-1:0] RST_PC = 32'h8000_0000;

  logic              clk;
  logic              rst_n;
  logic              pipe_stall;
  logic              pipe_flush;
  logic              ex_bj_flag;
  logic              ex_is_mret_inst;
  logic              if_valid;
  logic              if_allowin;
  logic [XLEN-1:0]   if_pc;
  logic [XLEN-1:0]   if_inst;
  logic              if_exp_flag;
  logic              if_inst_addr_misal;
  logic              id_valid;
  logic              id_allowin;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_inst;
  logic              id_exp_flag;
  logic              id_inst_addr_misal;
  logic [$clog2(DEPTH):0] q_count;
  logic              q_full;

  int n_checks = 0;
  int n_errors = 0;

  if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RST_PC(RST_PC)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pipe_stall         (pipe_stall),
    .pipe_flush         (pipe_flush),
    .ex_bj_flag         (ex_bj_flag),
    .ex_is_mret_inst    (ex_is_mret_inst),
    .if_valid           (if_valid),
    .if_allowin         (if_allowin),
    .if_pc              (if_pc),
    .if_inst            (if_inst),
    .if_exp_flag        (if_exp_flag),
    .if_inst_addr_misal (if_inst_addr_misal),
    .id_valid           (id_valid),
    .id_allowin         (id_allowin),
    .id_pc              (id_pc),
    .id_inst            (id_inst),
    .id_exp_flag        (id_exp_flag),
    .id_inst_addr_misal (id_inst_addr_misal),
    .q_count            (q_count),
    .q_full             (q_full)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [XLEN-1:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_inst  = pc ^ 32'h0000_0013;
  endtask

  initial begin
    rst_n = 1'b0; pipe_stall = 1'b0; pipe_flush = 1'b0; ex_bj_flag = 1'b0;
    ex_is_mret_inst = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    if_exp_flag = 1'b0; if_inst_addr_misal = 1'b0; id_allowin = 1'b0;

    // Reset values
    #12;
    check("rst_id_valid", id_valid, 0);
    check("rst_id_pc", id_pc, RST_PC);
    check("rst_id_inst", id_inst, 0);
    check("rst_q_count", q_count, 0);
    check("rst_q_full", q_full, 0);
    check("rst_if_allowin", if_allowin, 1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Single push: no bypass, visible next cycle, popped the cycle after.
    if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h0000_0013; id_allowin = 1'b1;
    #1;
    check("t1_no_bypass", id_valid, 0);
    check("t1_count0", q_count, 0);
    tick();
    if_valid = 1'b0;
    #1;
    check("t1_valid", id_valid, 1);
    check("t1_pc", id_pc, 32'h100);
    check("t1_inst", id_inst, 32'h13);
    check("t1_count1", q_count, 1);
    tick();
    check("t1_count_drained", q_count, 0);
    check("t1_valid_drained", id_valid, 0);

    // Fill with decoder stalled: the fifth push must be refused.
    id_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_push(1'b1, 32'(4 * i));
      #1;
      check($sformatf("fill_allowin_%0d", i), if_allowin, (i < 4) ? 1 : 0);
      tick();
    end
    check("fill_full", q_full, 1);
    check("fill_count", q_count, 4);
    // Decoder resumes: 0x10 is accepted in the first pop cycle.
    id_allowin = 1'b1;
    #1;
    check("fill_allowin_on_pop", if_allowin, 1);
    check("fill_head0", id_pc, 32'h0);
    tick();
    check("fill_count_after", q_count, 4);
    // Full push+pop with 0x20: write wraps through slot 1.
    drive_push(1'b1, 32'h20);
    #1;
    check("pp_head", id_pc, 32'h4);
    check("pp_allowin", if_allowin, 1);
    tick();
    drive_push(1'b0, 32'h0);
    check("pp_count", q_count, 4);
    for (int j = 0; j < 4; j++) begin
      logic [XLEN-1:0] exp_pc;
      exp_pc = (j == 0) ? 32'h8 : (j == 1) ? 32'hC : (j == 2) ? 32'h10 : 32'h20;
      check($sformatf("drain_pc_%0d", j), id_pc, exp_pc);
      check($sformatf("drain_inst_%0d", j), id_inst, exp_pc ^ 32'h13);
      tick();
    end
    check("drain_empty", q_count, 0);

    // Three entries, then a taken branch while fetch pushes 0x40.
    id_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 32'(32'h30 + 4 * i));
      tick();
    end
    check("bj_pre_count", q_count, 3);
    drive_push(1'b1, 32'h40); id_allowin = 1'b1; ex_bj_flag = 1'b1;
    #1;
    check("bj_id_valid", id_valid, 0);
    check("bj_if_allowin", if_allowin, 0);
    tick();
    ex_bj_flag = 1'b0; drive_push(1'b0, 32'h0);
    check("bj_count", q_count, 0);
    check("bj_id_valid_next", id_valid, 0);
    tick();
    check("bj_not_stored", q_count, 0);

    // mret redirect also flushes; pipe_flush too.
    id_allowin = 1'b0;
    drive_push(1'b1, 32'h44);
    tick();
    drive_push(1'b0, 32'h0); ex_is_mret_inst = 1'b1;
    #1;
    check("mret_id_valid", id_valid, 0);
    tick();
    ex_is_mret_inst = 1'b0;
    check("mret_count", q_count, 0);
    drive_push(1'b1, 32'h48);
    tick();
    drive_push(1'b0, 32'h0); pipe_flush = 1'b1;
    tick();
    pipe_flush = 1'b0;
    check("pflush_count", q_count, 0);

    // Fetch stall still lets decode drain.
    drive_push(1'b1, 32'h50); tick();
    drive_push(1'b1, 32'h54); tick();
    drive_push(1'b1, 32'h58); pipe_stall = 1'b1; id_allowin = 1'b1;
    #1;
    check("stall_allowin", if_allowin, 0);
    check("stall_head0", id_pc, 32'h50);
    tick();
    check("stall_head1", id_pc, 32'h54);
    check("stall_count1", q_count, 1);
    tick();
    check("stall_count0", q_count, 0);
    check("stall_valid0", id_valid, 0);
    pipe_stall = 1'b0;

    // Push and pop requested on an empty queue: push stored, flags carried.
    drive_push(1'b1, 32'h102); if_exp_flag = 1'b1; if_inst_addr_misal = 1'b1;
    #1;
    check("flag_empty_no_pop", id_valid, 0);
    tick();
    id_allowin = 1'b0; if_exp_flag = 1'b0; if_inst_addr_misal = 1'b0;
    drive_push(1'b1, 32'h106);
    #1;
    check("flag_valid", id_valid, 1);
    check("flag_pc", id_pc, 32'h102);
    check("flag_exp", id_exp_flag, 1);
    check("flag_misal", id_inst_addr_misal, 1);
    tick();
    drive_push(1'b0, 32'h0);
    check("flag_count2", q_count, 2);

    // Asynchronous reset mid-stream, away from the clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", id_valid, 0);
    check("arst_count", q_count, 0);
    check("arst_pc", id_pc, RST_PC);
    check("arst_inst", id_inst, 0);
    check("arst_exp", id_exp_flag, 0);
    check("arst_misal", id_inst_addr_misal, 0);
    check("arst_allowin", if_allowin, 1);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("arst_stays_empty", q_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
